// File: rtl/kryp_pkg.sv
// Shared definitions for the control unit and datapath: widths, B-bus source codes,
// ALU op codes and selector bit indices.
package kryp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IR_W   = 8;
  localparam int unsigned BSEL_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 17;

  // B-bus source codes; 13-15 drive zero
  localparam logic [BSEL_W-1:0] DATA_FROM_RAM = 4'd0;
  localparam logic [BSEL_W-1:0] DATA_FROM_PC  = 4'd1;
  localparam logic [BSEL_W-1:0] DATA_FROM_R1  = 4'd2;
  localparam logic [BSEL_W-1:0] DATA_FROM_R2  = 4'd3;
  localparam logic [BSEL_W-1:0] DATA_FROM_R3  = 4'd4;
  localparam logic [BSEL_W-1:0] DATA_FROM_AS  = 4'd5;
  localparam logic [BSEL_W-1:0] DATA_FROM_TR  = 4'd6;
  localparam logic [BSEL_W-1:0] DATA_FROM_MR  = 4'd7;
  localparam logic [BSEL_W-1:0] DATA_FROM_R   = 4'd8;
  localparam logic [BSEL_W-1:0] DATA_FROM_AC  = 4'd9;
  localparam logic [BSEL_W-1:0] DATA_FROM_IM  = 4'd10;
  localparam logic [BSEL_W-1:0] DATA_FROM_AR  = 4'd11;
  localparam logic [BSEL_W-1:0] DATA_FROM_TM  = 4'd12;

  // ALU op codes; 6-7 behave as PASSB
  localparam logic [OP_W-1:0] ADDAB = 3'd0;
  localparam logic [OP_W-1:0] SUBAB = 3'd1;
  localparam logic [OP_W-1:0] PASSB = 3'd2;
  localparam logic [OP_W-1:0] ZER   = 3'd3;
  localparam logic [OP_W-1:0] MULAB = 3'd4;
  localparam logic [OP_W-1:0] MULMA = 3'd5;

  // Selector bit indices
  localparam int unsigned SEL_DMEM_WE = 0;
  localparam int unsigned SEL_AC      = 1;
  localparam int unsigned SEL_TR      = 2;
  localparam int unsigned SEL_MR      = 3;
  localparam int unsigned SEL_AS      = 4;
  localparam int unsigned SEL_R       = 5;
  localparam int unsigned SEL_R3      = 6;
  localparam int unsigned SEL_R2      = 7;
  localparam int unsigned SEL_R1      = 8;
  localparam int unsigned SEL_PC      = 9;
  localparam int unsigned SEL_AR      = 10;
  localparam int unsigned SEL_AS_INC  = 11;
  localparam int unsigned SEL_R3_INC  = 12;
  localparam int unsigned SEL_R2_INC  = 13;
  localparam int unsigned SEL_R1_INC  = 14;
  localparam int unsigned SEL_PC_INC  = 15;
  localparam int unsigned SEL_TM      = 16;

endpackage

// File: rtl/datapath_if.sv
// Control-word and memory bus between control unit / RAMs (master) and datapath (slave).
interface datapath_if;
  import kryp_pkg::*;

  logic              fetch;
  logic              finish;
  logic [BSEL_W-1:0] b_bus_select;
  logic [OP_W-1:0]   alu_op;
  logic [SEL_W-1:0]  selectors;
  logic [ADDR_W-1:0] imem_addr;
  logic [IR_W-1:0]   imem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic [IR_W-1:0]   instruction;
  logic              Z;
  logic [DATA_W-1:0] ac_out;

  modport master (
    output fetch, finish, b_bus_select, alu_op, selectors, imem_rdata, dmem_rdata,
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we, instruction, Z, ac_out
  );

  modport slave (
    input  fetch, finish, b_bus_select, alu_op, selectors, imem_rdata, dmem_rdata,
    output imem_addr, dmem_addr, dmem_wdata, dmem_we, instruction, Z, ac_out
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A = AC, B = bus. Multiplier present only with DATAPATH_MUL_EN
// defined; otherwise MUL ops return A unchanged.
module alu
  import kryp_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [DATA_W-1:0] mul_lo;

`ifdef DATAPATH_MUL_EN
  assign mul_lo = a_i * b_i;
`else
  assign mul_lo = a_i;
`endif

  always_comb begin
    result_o = b_i;
    case (op_i)
      ADDAB:        result_o = a_i + b_i;
      SUBAB:        result_o = a_i - b_i;
      PASSB:        result_o = b_i;
      ZER:          result_o = '0;
      MULAB, MULMA: result_o = mul_lo;
      default:      result_o = b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/datapath.sv
// Architectural registers, 13-source B-bus, ALU and zero flag; updates on posedge.
// Optional multiplier enabled by defining DATAPATH_MUL_EN.
module datapath
  import kryp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  datapath_if.slave dp
);

  logic [DATA_W-1:0] ac_q, ac_d, tr_q, tr_d, mr_q, mr_d, r_q, r_d, tm_q, tm_d;
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, as_q, as_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              z_q, z_d;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic [SEL_W-1:0]  sel;

  assign sel = dp.selectors;

  // B-bus source mux
  always_comb begin
    bus = '0;
    case (dp.b_bus_select)
      DATA_FROM_RAM: bus = dp.dmem_rdata;
      DATA_FROM_PC:  bus = DATA_W'(pc_q);
      DATA_FROM_R1:  bus = r1_q;
      DATA_FROM_R2:  bus = r2_q;
      DATA_FROM_R3:  bus = r3_q;
      DATA_FROM_AS:  bus = as_q;
      DATA_FROM_TR:  bus = tr_q;
      DATA_FROM_MR:  bus = mr_q;
      DATA_FROM_R:   bus = r_q;
      DATA_FROM_AC:  bus = ac_q;
      DATA_FROM_IM:  bus = DATA_W'(dp.imem_rdata);
      DATA_FROM_AR:  bus = DATA_W'(ar_q);
      DATA_FROM_TM:  bus = tm_q;
      default:       bus = '0;
    endcase
  end

  alu u_alu (
    .a_i      (ac_q),
    .b_i      (bus),
    .op_i     (dp.alu_op),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Next-state: increments first so a same-cycle load overrides them; finish freezes all
  always_comb begin
    ac_d = ac_q;
    tr_d = tr_q;
    mr_d = mr_q;
    r_d  = r_q;
    tm_d = tm_q;
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    as_d = as_q;
    pc_d = pc_q;
    ar_d = ar_q;
    ir_d = ir_q;
    z_d  = z_q;
    if (!dp.finish) begin
      if (sel[SEL_AS_INC]) as_d = as_q + DATA_W'(1);
      if (sel[SEL_R3_INC]) r3_d = r3_q + DATA_W'(1);
      if (sel[SEL_R2_INC]) r2_d = r2_q + DATA_W'(1);
      if (sel[SEL_R1_INC]) r1_d = r1_q + DATA_W'(1);
      if (sel[SEL_PC_INC]) pc_d = pc_q + ADDR_W'(1);

      if (sel[SEL_AC]) begin
        ac_d = alu_res;
        z_d  = alu_zero;
      end
      if (sel[SEL_TR]) tr_d = alu_res;
      if (sel[SEL_MR]) mr_d = alu_res;
      if (sel[SEL_AS]) as_d = alu_res;
      if (sel[SEL_R])  r_d  = alu_res;
      if (sel[SEL_R3]) r3_d = alu_res;
      if (sel[SEL_R2]) r2_d = alu_res;
      if (sel[SEL_R1]) r1_d = alu_res;
      if (sel[SEL_PC]) pc_d = ADDR_W'(alu_res);
      if (sel[SEL_AR]) ar_d = ADDR_W'(alu_res);
      if (sel[SEL_TM]) tm_d = alu_res;
      if (dp.fetch)    ir_d = dp.imem_rdata;
    end
  end

  // State register with synchronous reset; Z resets to 1 to match AC = 0
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q <= '0;
      tr_q <= '0;
      mr_q <= '0;
      r_q  <= '0;
      tm_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      as_q <= '0;
      pc_q <= '0;
      ar_q <= '0;
      ir_q <= '0;
      z_q  <= 1'b1;
    end else begin
      ac_q <= ac_d;
      tr_q <= tr_d;
      mr_q <= mr_d;
      r_q  <= r_d;
      tm_q <= tm_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      as_q <= as_d;
      pc_q <= pc_d;
      ar_q <= ar_d;
      ir_q <= ir_d;
      z_q  <= z_d;
    end
  end

  assign dp.imem_addr   = pc_q;
  assign dp.dmem_addr   = ar_q;
  assign dp.dmem_wdata  = alu_res;
  assign dp.dmem_we     = sel[SEL_DMEM_WE] & ~dp.finish & ~rst;
  assign dp.instruction = ir_q;
  assign dp.Z           = z_q;
  assign dp.ac_out      = ac_q;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_datapath;
  import kryp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  datapath_if dp_if ();

  datapath dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] bsel, input logic [2:0] op,
                       input logic [16:0] sel, input logic [7:0] imem);
    dp_if.b_bus_select = bsel;
    dp_if.alu_op       = op;
    dp_if.selectors    = sel;
    dp_if.imem_rdata   = imem;
  endtask

  function automatic logic [16:0] bit_of(input int unsigned idx);
    return 17'(1) << idx;
  endfunction

  logic [15:0] mul_exp;

  initial begin
`ifdef DATAPATH_MUL_EN
    mul_exp = 16'd42;
`else
    mul_exp = 16'd6;
`endif
    rst              = 1'b1;
    dp_if.fetch      = 1'b0;
    dp_if.finish     = 1'b0;
    dp_if.dmem_rdata = 16'h1234;
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_DMEM_WE) | bit_of(SEL_AC), 8'h77);
    tick();
    tick();
    chk("rst_ac", 32'(dp_if.ac_out), 32'h0);
    chk("rst_z", 32'(dp_if.Z), 32'h1);
    chk("rst_we", 32'(dp_if.dmem_we), 32'h0);
    chk("rst_ir", 32'(dp_if.instruction), 32'h0);
    chk("rst_pc", 32'(dp_if.imem_addr), 32'h0);
    chk("rst_ar", 32'(dp_if.dmem_addr), 32'h0);

    rst = 1'b0;
    dp_if.fetch = 1'b1;
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_AC), 8'h05);
    tick();
    dp_if.fetch = 1'b0;
    chk("pass_ac", 32'(dp_if.ac_out), 32'h5);
    chk("pass_z", 32'(dp_if.Z), 32'h0);
    chk("fetch_ir", 32'(dp_if.instruction), 32'h5);

    drive(DATA_FROM_IM, ZER, bit_of(SEL_AC), 8'h05);
    tick();
    chk("zer_ac", 32'(dp_if.ac_out), 32'h0);
    chk("zer_z", 32'(dp_if.Z), 32'h1);

    drive(DATA_FROM_IM, PASSB, bit_of(SEL_AC), 8'h07);
    tick();
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_TR), 8'h09);
    tick();
    chk("tr_load_ac_hold", 32'(dp_if.ac_out), 32'h7);
    chk("tr_load_z_hold", 32'(dp_if.Z), 32'h0);

    drive(DATA_FROM_TR, SUBAB, bit_of(SEL_AC), 8'h00);
    #1;
    chk("sub_wdata", 32'(dp_if.dmem_wdata), 32'hFFFE);
    tick();
    chk("sub_ac", 32'(dp_if.ac_out), 32'hFFFE);
    chk("sub_z", 32'(dp_if.Z), 32'h0);

    drive(DATA_FROM_IM, ADDAB, bit_of(SEL_R1), 8'h01);
    tick();
    drive(DATA_FROM_R1, PASSB, '0, 8'h00);
    #1;
    chk("r1_full", 32'(dp_if.dmem_wdata), 32'hFFFF);
    drive(DATA_FROM_R1, PASSB, bit_of(SEL_R1_INC), 8'h00);
    tick();
    drive(DATA_FROM_R1, PASSB, bit_of(SEL_AC), 8'h00);
    tick();
    chk("r1_wrap_ac", 32'(dp_if.ac_out), 32'h0);
    chk("r1_wrap_z", 32'(dp_if.Z), 32'h1);

    drive(DATA_FROM_IM, PASSB, bit_of(SEL_PC), 8'h03);
    tick();
    chk("pc_load", 32'(dp_if.imem_addr), 32'h3);
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_PC) | bit_of(SEL_PC_INC), 8'h20);
    tick();
    chk("pc_load_wins", 32'(dp_if.imem_addr), 32'h20);
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_PC_INC), 8'h00);
    tick();
    chk("pc_inc", 32'(dp_if.imem_addr), 32'h21);
    drive(DATA_FROM_PC, PASSB, '0, 8'h00);
    #1;
    chk("bus_pc", 32'(dp_if.dmem_wdata), 32'h21);

    drive(DATA_FROM_IM, PASSB, bit_of(SEL_AC), 8'h06);
    tick();
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_MR), 8'h07);
    tick();
    chk("mr_load_ac_hold", 32'(dp_if.ac_out), 32'h6);
    drive(DATA_FROM_MR, MULAB, bit_of(SEL_AC), 8'h00);
    tick();
    chk("mul_ac", 32'(dp_if.ac_out), 32'(mul_exp));
    chk("mul_z", 32'(dp_if.Z), 32'h0);

    drive(DATA_FROM_IM, PASSB, bit_of(SEL_AR) | bit_of(SEL_DMEM_WE), 8'h44);
    #1;
    chk("we_on", 32'(dp_if.dmem_we), 32'h1);
    tick();
    chk("ar_load", 32'(dp_if.dmem_addr), 32'h44);
    drive(DATA_FROM_RAM, PASSB, '0, 8'h00);
    #1;
    chk("bus_ram", 32'(dp_if.dmem_wdata), 32'h1234);
    drive(4'd13, ADDAB, '0, 8'h00);
    #1;
    chk("bus_zero", 32'(dp_if.dmem_wdata), 32'(mul_exp));

    dp_if.finish = 1'b1;
    dp_if.fetch  = 1'b1;
    drive(DATA_FROM_IM, PASSB,
          bit_of(SEL_DMEM_WE) | bit_of(SEL_AC) | bit_of(SEL_PC_INC), 8'h99);
    #1;
    chk("fin_we", 32'(dp_if.dmem_we), 32'h0);
    tick();
    chk("fin_ac", 32'(dp_if.ac_out), 32'(mul_exp));
    chk("fin_pc", 32'(dp_if.imem_addr), 32'h21);
    chk("fin_ir", 32'(dp_if.instruction), 32'h5);
    dp_if.finish = 1'b0;
    dp_if.fetch  = 1'b0;

    drive(DATA_FROM_IM, PASSB, bit_of(SEL_AC), 8'h55);
    tick();
    chk("pre_rst_ac", 32'(dp_if.ac_out), 32'h55);
    rst = 1'b1;
    dp_if.fetch = 1'b1;
    drive(DATA_FROM_IM, PASSB, bit_of(SEL_AC) | bit_of(SEL_PC), 8'h66);
    tick();
    chk("mid_rst_ac", 32'(dp_if.ac_out), 32'h0);
    chk("mid_rst_z", 32'(dp_if.Z), 32'h1);
    chk("mid_rst_pc", 32'(dp_if.imem_addr), 32'h0);
    chk("mid_rst_ar", 32'(dp_if.dmem_addr), 32'h0);
    chk("mid_rst_ir", 32'(dp_if.instruction), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Register-and-bus datapath directly downstream of `control_unit`: consumes its `fetch`, `b_bus_select`, `alu_op`, `selectors` and `finish` outputs and returns `instruction` and `Z`. Holds the processor's architectural registers, the 13-source B-bus mux, the ALU and the zero flag. It presents addresses to the instruction and data RAMs. State updates on `posedge clk`, opposite the control unit's negedge state change, so every control word is stable for half a cycle before it is acted on.

## Interface
- `DATA_W`, 16: width of AC, TR, MR, R, R1–R3, AS, TM, B-bus and ALU.
- `ADDR_W`, 16: width of PC and AR.
- `clk`  in  1  system clock; all registers update on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch`  in  1  load IR from `imem_rdata`.
- `finish`  in  1  program ended; suppresses all register and RAM writes.
- `b_bus_select`  in  4  B-bus source code.
- `alu_op`  in  3  ALU operation code.
- `selectors`  in  17  one-hot-per-bit write enables.
- `imem_addr`  out  ADDR_W  = PC.
- `imem_rdata`  in  8  instruction/operand byte at PC.
- `dmem_addr`  out  ADDR_W  = AR.
- `dmem_rdata`  in  DATA_W  data RAM read word.
- `dmem_wdata`  out  DATA_W  = ALU result.
- `dmem_we`  out  1  = `selectors[0]` & ~`finish`.
- `instruction`  out  8  = IR.
- `Z`  out  1  registered zero flag.
- `ac_out`  out  DATA_W  = AC, for debug and bench.

## Operation
- **B-bus sources:**
  - 0: `dmem_rdata`
  - 1: PC
  - 2: R1
  - 3: R2
  - 4: R3
  - 5: AS
  - 6: TR
  - 7: MR
  - 8: R
  - 9: AC
  - 10: `imem_rdata` zero-extended
  - 11: AR
  - 12: TM
  - 13–15: bus = 0
- **ALU ops**, with A = AC and B = bus, all results truncated to DATA_W, wrapping:
  - 0: A+B
  - 1: A−B
  - 2: B
  - 3: 0
  - 4: A×B (MULAB)
  - 5: A×B (MULMA)
  - 6–7: B
- **Selector bits** (destination ← ALU result unless noted):
  - 0: data RAM write
  - 1: AC
  - 2: TR
  - 3: MR
  - 4: AS
  - 5: R
  - 6: R3
  - 7: R2
  - 8: R1
  - 9: PC ← ALU result[ADDR_W-1:0]
  - 10: AR
  - 11: AS+1
  - 12: R3+1
  - 13: R2+1
  - 14: R1+1
  - 15: PC+1
  - 16: TM
- **Increments** use dedicated +1 adders, independent of the ALU, and wrap at all-ones to 0.
- **Load vs increment on the same register in one cycle** (bits 4/11, 6/12, 7/13, 8/14, 9/15): the load wins.
- **IR** ← `imem_rdata` when `fetch`=1.
- **Z** ← (ALU result == 0) on every AC write; otherwise Z holds.
- **`finish`=1:** no register, IR, Z or RAM write occurs; outputs hold their values.
- **Reset:**
  - All registers, IR and outputs are 0, except Z, which is 1 (AC=0).
  - `dmem_we` is 0 while `rst` is high.
  - Reset is honoured mid-instruction, with no partial write.

## Timing
- ALU and bus are purely combinational from registered state plus control inputs.
- A write selected by a control word takes effect on the next rising edge. The new value is visible on outputs after that edge.
- Z changes on the same edge as AC.
- `dmem_we` is combinational from `selectors[0]`. The RAM captures `dmem_wdata` at rising edge.
- IR loaded on the posedge during FETCH2 is stable before the control unit's FETCH4 negedge decode.
- Single-cycle throughput: one register-transfer per clock. No handshakes, no stalls.

## Configuration
- **`DATAPATH_MUL_EN` defined:** ALU ops 4 and 5 instantiate the DATA_W×DATA_W multiplier and return the low DATA_W bits.
- **Undefined:** no multiplier is synthesised. Ops 4 and 5 return A, so AC is unchanged on MUL and MULM1.

## Structure
- **Shared package `kryp_pkg`:**
  - bus-source localparams (DATA_FROM_RAM…TM)
  - ALU op codes (ADDAB…MULMA)
  - selector bit indices (SEL_DMEM_WE…SEL_TM)
- The control unit is to import the same package.
- **One sub-module `alu`:**
  - inputs: A, B, op
  - outputs: result, zero
  - holds the `DATAPATH_MUL_EN` guard.

## Test plan
- Reset with `rst`=1 for 2 cycles → all registers 0, Z=1, `dmem_we`=0, `instruction`=0.
- bus=10, `imem_rdata`=0x05, op PASS, sel bit1 → AC=5, Z=0; then op ZER, bit1 → AC=0, Z=1.
- AC=7, TR=9, bus=6, op SUBAB, bit1 → AC=0xFFFE, Z=0; R1=0xFFFF with bit14 → R1=0.
- PC=3 with bits 9 and 15 both set, ALU result 0x20 → PC=0x20, not 4.
- AC=6, MR=7, op MULAB, bit1 → AC=42 with `DATAPATH_MUL_EN` defined, AC=6 without.
- `finish`=1 with bits 0, 1 and 15 set → `dmem_we`=0, AC and PC unchanged; `rst` asserted mid-sequence → state returns to reset values next edge.
